// File: rtl/branch_resolver.sv
// EX-stage branch resolution: holds the branch in the EX register, works out the real outcome,
// raises the flush and redirect PC on a mispredict, and keeps saturating branch/mispredict counters.
module branch_resolver #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PL_stall,
    input  logic                 B_type_id,
    input  logic                 beq_id,
    input  logic                 bne_id,
    input  logic                 blt_id,
    input  logic                 bge_id,
    input  logic                 bltu_id,
    input  logic                 bgeu_id,
    input  logic [31:0]          pc_id,
    input  logic [31:0]          imme_id,
    input  logic                 B_type_prediction_result_id,
    input  logic [31:0]          rs1_data_ex,
    input  logic [31:0]          rs2_data_ex,
    output logic                 B_type_branch_failed,
    output logic                 beq_branch_failed,
    output logic                 bne_branch_failed,
    output logic                 blt_branch_failed,
    output logic                 bge_branch_failed,
    output logic                 bltu_branch_failed,
    output logic                 bgeu_branch_failed,
    output logic [31:0]          pc_branch_filled,
    output logic                 B_type_prediction_result_branch_failed,
    output logic                 corrected_result,
    output logic                 PL_flush,
    output logic [31:0]          redirect_pc,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispredict_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 r_b_type, r_beq, r_bne, r_blt, r_bge, r_bltu, r_bgeu;
    logic [31:0]          r_pc;
    logic [31:0]          r_imme;
    logic                 r_pred;
    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_mispredict_cnt;

    logic w_eq, w_lt_s, w_lt_u;
    logic w_taken, w_flush, w_retire;

    assign w_eq   = (rs1_data_ex == rs2_data_ex);
    assign w_lt_s = ($signed(rs1_data_ex) < $signed(rs2_data_ex));
    assign w_lt_u = (rs1_data_ex < rs2_data_ex);

    assign w_taken = r_b_type & ((r_beq  &  w_eq)   | (r_bne  & ~w_eq)   |
                                 (r_blt  &  w_lt_s) | (r_bge  & ~w_lt_s) |
                                 (r_bltu &  w_lt_u) | (r_bgeu & ~w_lt_u));
    assign w_flush  = r_b_type & (w_taken != r_pred);
    // A flush retires the branch even under stall, since the bubble replaces it.
    assign w_retire = r_b_type & (~PL_stall | w_flush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b_type <= 1'b0;
            r_beq    <= 1'b0;
            r_bne    <= 1'b0;
            r_blt    <= 1'b0;
            r_bge    <= 1'b0;
            r_bltu   <= 1'b0;
            r_bgeu   <= 1'b0;
            r_pc     <= 32'd0;
            r_imme   <= 32'd0;
            r_pred   <= 1'b0;
        end else if (w_flush) begin
            r_b_type <= 1'b0;
            r_beq    <= 1'b0;
            r_bne    <= 1'b0;
            r_blt    <= 1'b0;
            r_bge    <= 1'b0;
            r_bltu   <= 1'b0;
            r_bgeu   <= 1'b0;
        end else if (!PL_stall) begin
            r_b_type <= B_type_id;
            r_beq    <= beq_id;
            r_bne    <= bne_id;
            r_blt    <= blt_id;
            r_bge    <= bge_id;
            r_bltu   <= bltu_id;
            r_bgeu   <= bgeu_id;
            r_pc     <= pc_id;
            r_imme   <= imme_id;
            r_pred   <= B_type_prediction_result_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (w_retire) begin
            if (r_branch_cnt != CNT_MAX) r_branch_cnt <= r_branch_cnt + CNT_ONE;
            if (w_flush && (r_mispredict_cnt != CNT_MAX))
                r_mispredict_cnt <= r_mispredict_cnt + CNT_ONE;
        end
    end

    assign B_type_branch_failed                   = r_b_type;
    assign beq_branch_failed                      = r_beq;
    assign bne_branch_failed                      = r_bne;
    assign blt_branch_failed                      = r_blt;
    assign bge_branch_failed                      = r_bge;
    assign bltu_branch_failed                     = r_bltu;
    assign bgeu_branch_failed                     = r_bgeu;
    assign pc_branch_filled                       = r_pc;
    assign B_type_prediction_result_branch_failed = r_pred;
    assign corrected_result                       = w_taken;
    assign PL_flush                               = w_flush;
    assign redirect_pc    = w_taken ? (r_pc + r_imme) : (r_pc + 32'd4);
    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule
